// File: rtl/shift_piso_tx.sv
// Parallel-in, serial-out shift transmitter with a valid/ready load handshake.
// Frames are sent back to back: a new word is accepted during the final bit.
// Optional feature macro: PISO_PARITY_EN appends an even-parity bit to each frame.
module shift_piso_tx #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] parallel_in,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             last_bit,
    output logic             busy
);

`ifdef PISO_PARITY_EN
    localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
    localparam int unsigned FRAME_LEN = WIDTH;
`endif
    localparam int unsigned CNT_W = $clog2(WIDTH + 2);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [FRAME_LEN-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 sout_q, sout_d;
    logic                 sval_q, sval_d;
    logic                 last_q, last_d;

    logic [WIDTH-1:0]     data_ord_c;
    logic [FRAME_LEN-1:0] frame_c;
    logic                 accept_c;

    // Arrange the incoming word so the first bit to send sits at the top of the frame
    always_comb begin
        data_ord_c = parallel_in;
        if (!MSB_FIRST) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                data_ord_c[i] = parallel_in[WIDTH-1-i];
            end
        end
`ifdef PISO_PARITY_EN
        frame_c = {data_ord_c, ^parallel_in};
`else
        frame_c = data_ord_c;
`endif
    end

    assign load_ready = (state_q == IDLE) || last_q;
    assign accept_c   = load_valid && load_ready;

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        sout_d  = sout_q;
        sval_d  = sval_q;
        last_d  = last_q;
        if (accept_c) begin
            state_d = SHIFT;
            sout_d  = frame_c[FRAME_LEN-1];
            shreg_d = {frame_c[FRAME_LEN-2:0], 1'b0};
            sval_d  = 1'b1;
            cnt_d   = '0;
            last_d  = 1'b0;
        end else if (state_q == SHIFT) begin
            if (last_q) begin
                state_d = IDLE;
                shreg_d = '0;
                cnt_d   = '0;
                sout_d  = 1'b0;
                sval_d  = 1'b0;
                last_d  = 1'b0;
            end else begin
                sout_d  = shreg_q[FRAME_LEN-1];
                shreg_d = {shreg_q[FRAME_LEN-2:0], 1'b0};
                cnt_d   = cnt_q + CNT_W'(1);
                last_d  = (cnt_q + CNT_W'(1)) == CNT_W'(FRAME_LEN - 1);
            end
        end
    end

    // State and output registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            sout_q  <= 1'b0;
            sval_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            sout_q  <= sout_d;
            sval_q  <= sval_d;
            last_q  <= last_d;
        end
    end

    assign serial_out   = sout_q;
    assign serial_valid = sval_q;
    assign last_bit     = last_q;
    assign busy         = (state_q == SHIFT);

endmodule
